vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen.sv | 123 ++++++++++++
 tb/tb_vga_timing_gen.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing: pixel-enable divider, h/v counters, registered syncs and frame strobe.
// Define VGA_TIMING_FRAME_CNT_EN to add a 16-bit free-running frame counter output (frame_cnt).
module vga_timing_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_tick
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS      = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START   = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END     = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_START   = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END     = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DIV_W-1:0] div_cnt_reg;
    logic [DIV_W-1:0] div_cnt_next;
    logic [9:0]       hcount_reg;
    logic [9:0]       hcount_next;
    logic [9:0]       vcount_reg;
    logic [9:0]       vcount_next;
    logic             p_tick_reg;
    logic             frame_tick_reg;
    logic             hsync_reg;
    logic             hsync_next;
    logic             vsync_reg;
    logic             vsync_next;
    logic             pix_end;
    logic             line_end;
    logic             frame_wrap;

    // Counts advance on the same edge that raises p_tick, so p_tick marks a fresh pixel.
    always_comb begin
        pix_end      = (div_cnt_reg == DIV_LAST);
        line_end     = pix_end && (hcount_reg == H_LAST);
        frame_wrap   = line_end && (vcount_reg == V_LAST);
        div_cnt_next = pix_end ? '0 : div_cnt_reg + 1'b1;

        hcount_next = hcount_reg;
        if (pix_end) begin
            hcount_next = (hcount_reg == H_LAST) ? 10'd0 : hcount_reg + 10'd1;
        end

        vcount_next = vcount_reg;
        if (line_end) begin
            vcount_next = (vcount_reg == V_LAST) ? 10'd0 : vcount_reg + 10'd1;
        end

        // Syncs decode the next counts so they register in step with hcount/vcount.
        hsync_next = !((hcount_next >= HS_START) && (hcount_next <= HS_END));
        vsync_next = !((vcount_next >= VS_START) && (vcount_next <= VS_END));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_reg    <= '0;
            hcount_reg     <= 10'd0;
            vcount_reg     <= 10'd0;
            p_tick_reg     <= 1'b0;
            frame_tick_reg <= 1'b0;
            hsync_reg      <= 1'b1;
            vsync_reg      <= 1'b1;
        end else begin
            div_cnt_reg    <= div_cnt_next;
            hcount_reg     <= hcount_next;
            vcount_reg     <= vcount_next;
            p_tick_reg     <= pix_end;
            frame_tick_reg <= frame_wrap;
            hsync_reg      <= hsync_next;
            vsync_reg      <= vsync_next;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt_reg <= 16'd0;
        end else if (frame_wrap) begin
            frame_cnt_reg <= frame_cnt_reg + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_reg;
`endif

    assign p_tick     = p_tick_reg;
    assign hcount     = hcount_reg;
    assign vcount     = vcount_reg;
    assign hsync      = hsync_reg;
    assign vsync      = vsync_reg;
    assign frame_tick = frame_tick_reg;
    assign video_on   = (hcount_reg < H_VIS) && (vcount_reg < V_VIS);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen using a reduced raster so several frames fit in a short run.
// Outputs are predicted from the number of clocks since reset release with plain arithmetic.
module tb_vga_timing_gen;

    localparam int CD = 4;
    localparam int HD = 16, HF = 4, HS = 6, HB = 4;
    localparam int VD = 10, VF = 2, VS = 2, VB = 3;
    localparam int HT = HD + HF + HS + HB;     // 30
    localparam int VT = VD + VF + VS + VB;     // 17
    localparam int FRAME_CLKS = HT * VT * CD;  // 2040

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       p_tick;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       video_on;
    logic       hsync;
    logic       vsync;
    logic       frame_tick;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int n = 0;
    int last_ft = -1;
    int ft_seen = 0;

    vga_timing_gen #(
        .CLK_DIV(CD),
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .p_tick(p_tick),
        .hcount(hcount),
        .vcount(vcount),
        .video_on(video_on),
        .hsync(hsync),
        .vsync(vsync),
        .frame_tick(frame_tick)
`ifdef VGA_TIMING_FRAME_CNT_EN
        ,
        .frame_cnt(frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Clocks elapsed since reset release.
    always @(posedge clk or posedge reset) begin
        if (reset) n <= 0;
        else       n <= n + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d n=%0d t=%0t", name, act, exp, n, $time);
        end
    endtask

    function automatic void model(input int k, output logic pt, output logic [9:0] h,
                                  output logic [9:0] v, output logic hs, output logic vs,
                                  output logic vo, output logic ft);
        int pix, hh, vv;
        pix = k / CD;
        hh  = pix % HT;
        vv  = (pix / HT) % VT;
        pt  = (k > 0) && (k % CD == 0);
        h   = 10'(hh);
        v   = 10'(vv);
        hs  = !(hh >= HD + HF && hh < HD + HF + HS);
        vs  = !(vv >= VD + VF && vv < VD + VF + VS);
        vo  = (hh < HD) && (vv < VD);
        ft  = pt && (pix % (HT * VT) == 0);
    endfunction

    task automatic chk_reset_values(input string tag);
        chk({tag, "_hcount"}, 32'(hcount), 32'd0);
        chk({tag, "_vcount"}, 32'(vcount), 32'd0);
        chk({tag, "_p_tick"}, 32'(p_tick), 32'd0);
        chk({tag, "_frame_tick"}, 32'(frame_tick), 32'd0);
        chk({tag, "_hsync"}, 32'(hsync), 32'd1);
        chk({tag, "_vsync"}, 32'(vsync), 32'd1);
        chk({tag, "_video_on"}, 32'(video_on), 32'd1);
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
`endif
    endtask

    // Per-cycle comparison against the model, sampled away from the active edge.
    always @(negedge clk) begin
        logic       e_pt, e_hs, e_vs, e_vo, e_ft;
        logic [9:0] e_h, e_v;
        if (reset) begin
            last_ft = -1;
            chk_reset_values("rst");
        end else begin
            model(n, e_pt, e_h, e_v, e_hs, e_vs, e_vo, e_ft);
            chk("p_tick", 32'(p_tick), 32'(e_pt));
            chk("hcount", 32'(hcount), 32'(e_h));
            chk("vcount", 32'(vcount), 32'(e_v));
            chk("hsync", 32'(hsync), 32'(e_hs));
            chk("vsync", 32'(vsync), 32'(e_vs));
            chk("video_on", 32'(video_on), 32'(e_vo));
            chk("frame_tick", 32'(frame_tick), 32'(e_ft));
`ifdef VGA_TIMING_FRAME_CNT_EN
            chk("frame_cnt", 32'(frame_cnt), 32'((n / FRAME_CLKS) % 65536));
`endif
            // Hand-computed points for the reduced raster.
            if (n == 4)    chk("lit_first_tick_h", 32'({p_tick, hcount}), 32'({1'b1, 10'd1}));
            if (n == 3)    chk("lit_no_tick_yet", 32'({p_tick, hcount}), 32'({1'b0, 10'd0}));
            if (n == 120)  chk("lit_line_wrap", 32'({hcount, vcount}), 32'({10'd0, 10'd1}));
            if (n == 79)   chk("lit_hsync_pre", 32'(hsync), 32'd1);
            if (n == 80)   chk("lit_hsync_low", 32'(hsync), 32'd0);
            if (n == 104)  chk("lit_hsync_back", 32'(hsync), 32'd1);
            if (n == 2040) chk("lit_frame_tick", 32'({frame_tick, hcount, vcount}), 32'({1'b1, 20'd0}));
            if (frame_tick) begin
                ft_seen++;
                if (last_ft >= 0) chk("frame_period", 32'(n - last_ft), 32'(FRAME_CLKS));
                last_ft = n;
            end
        end
    end

    initial begin
        int d;
        int hold;
        int run;
        reset = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        $display("release after 5 clk reset, running 2 frames");
        repeat (FRAME_CLKS * 2 + 500) @(posedge clk);

        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            d = $urandom_range(1, 4);
            #(d);
            reset = 1'b1;
            #1;
            chk_reset_values("async_rst");
            hold = $urandom_range(1, 5);
            repeat (hold) @(posedge clk);
            @(negedge clk);
            reset = 1'b0;
            run = $urandom_range(200, 3000);
            repeat (run) @(posedge clk);
            $display("reset episode %0d: offset=%0d hold=%0d run=%0d errors=%0d", k, d, hold, run, errors);
        end

        repeat (FRAME_CLKS + 100) @(posedge clk);
        @(negedge clk);
        chk("frame_tick_seen", 32'(ft_seen > 0), 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
